pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage 32-bit pipeline (IF, ID, EX, MEM, WB).
- Tracks in-flight destination registers in an internal 3-entry scoreboard shadowing the EX, MEM and WB stages.
- The pipeline has no forwarding paths and the register file has no write-through, so the block stalls IF/ID on every RAW hazard.
- When a taken branch resolves in MEM, it flushes the three younger instructions.
- Sits beside the pipeline registers and drives their enable, flush and bubble controls, plus the PC enable.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, width of saturating performance counters
MAX_STALL, 3, longest legal consecutive stall run; exceeding it sets err_sticky

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  IF_ID holds a real instruction
id_rs  in  REG_AW  source register 1 of the instruction in ID
id_rt  in  REG_AW  source register 2 of the instruction in ID
id_uses_rt  in  1  instruction in ID reads rt (R-type, store, beq)
id_rd  in  REG_AW  destination selected by ID (rd or rt after RegDst)
id_reg_write  in  1  instruction in ID writes the register file
pcsrc_mem  in  1  taken branch resolved in MEM this cycle
pc_en  out  1  PC may advance
if_id_en  out  1  IF_ID may load
if_id_flush  out  1  IF_ID loads a NOP
id_ex_bubble  out  1  ID_EX loads zero control bits
ex_mem_flush  out  1  EX_MEM loads zero control bits
stall  out  1  RAW stall active this cycle
state  out  2  0=RUN, 1=STALL, 2=FLUSH
stall_cnt  out  CNT_W  total stall cycles
flush_cnt  out  CNT_W  total taken-branch flushes
err_sticky  out  1  stall run exceeded MAX_STALL

Behaviour:
- Scoreboard entries sb_ex, sb_mem, sb_wb. Each entry holds {valid, addr}.
- Hazard, combinational:
  - raw = id_valid & !pcsrc_mem & ((id_rs!=0 & rs matches any valid entry) | (id_uses_rt & id_rt!=0 & rt matches any valid entry)).
  - stall = raw.
- Outputs (combinational, same cycle):
  - pc_en = if_id_en = !stall.
  - id_ex_bubble = stall | pcsrc_mem.
  - if_id_flush = ex_mem_flush = pcsrc_mem.
  - Flush has priority over stall. With pcsrc_mem=1, stall=0 and pc_en=1 (PC loads the branch target).
- Scoreboard update each clk:
  - sb_wb <= sb_mem.
  - If pcsrc_mem: sb_mem <= 0 and sb_ex <= 0.
  - Otherwise: sb_mem <= sb_ex, and sb_ex <= (stall | !id_valid) ? 0 : {id_reg_write & id_rd!=0, id_rd}.
- Maximum RAW stall is 3 cycles: a dependency on the EX entry clears after the WB write.
- FSM, registered:
  - RUN->STALL when stall.
  - STALL->RUN when !stall.
  - Any state->FLUSH when pcsrc_mem.
  - FLUSH->RUN the next cycle; the FLUSH cycle sees the flushed NOP in ID. A new stall in that cycle goes to STALL.
- Counters:
  - stall_cnt += 1 per stall cycle.
  - flush_cnt += 1 per pcsrc_mem cycle.
  - Both saturate at all-ones.
- Run counter:
  - Counts consecutive stall cycles and clears on !stall.
  - err_sticky sets when the run reaches MAX_STALL+1. It clears only on reset.
- Reset (rst_n=0 at clk edge):
  - Scoreboard invalid, state=RUN, counters=0, err_sticky=0.
  - Outputs are then pc_en=if_id_en=1 and the rest 0, given id_valid=0/pcsrc_mem=0.
  - Reset mid-stall or mid-flush abandons the operation with no residual stall.
- Register 0 never causes a hazard. Simultaneous rs and rt hits produce a single stall.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum {RUN, STALL, FLUSH};
  - scoreboard entry struct {valid, addr[REG_AW-1:0]};
  - REG_AW and the NOP encoding.
- One sub-module: sat_counter (parameter W, inc, rst_n), instantiated for stall_cnt and flush_cnt.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> pc_en=1, if_id_en=1, state=0, stall_cnt=0, flush_cnt=0, err_sticky=0.
- Issue add rd=3, then the next instruction reads rs=3 -> stall=1 for exactly 3 cycles, then stall=0; stall_cnt=3, state STALL then RUN.
- Issue rd=5, one independent instruction, then a reader of rt=5 with id_uses_rt=1 -> 2 stall cycles. Repeat the reader with id_uses_rt=0 -> 0 stalls.
- Issue a writer of rd=0, then a reader of rs=0 -> no stall.
- Stall in progress on rs=7 and pcsrc_mem=1 -> same cycle: stall=0, pc_en=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1. Next cycle: state=FLUSH, scoreboard EX/MEM entries cleared, flush_cnt=1.
- Force the scoreboard via a held id_valid reader with a sustained dependency (bench pokes sb_ex valid each cycle) -> err_sticky=1 on the 4th consecutive stall cycle. It stays 1 until rst_n=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipe_pkg;

  localparam int REG_AW = 5;

  // MIPS-style NOP (sll $0,$0,0) loaded into IF_ID on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
  } sb_entry_t;

  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_AW-1:0] a);
    return e.valid && (e.addr == a);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: RAW stall against an EX/MEM/WB destination
// scoreboard, taken-branch flush from MEM, and stall/flush statistics.
//
//   state | meaning
//   RUN   | pipeline advancing normally
//   STALL | previous cycle held IF/ID on a RAW hazard
//   FLUSH | previous cycle squashed the three younger instructions
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW    = pipe_pkg::REG_AW,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              pcsrc_mem,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_mem_flush,
  output logic              stall,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              err_sticky
);

  localparam int RUN_W = $clog2(MAX_STALL + 2);

  sb_entry_t        sb_ex_q, sb_ex_d;
  sb_entry_t        sb_mem_q, sb_mem_d;
  sb_entry_t        sb_wb_q;
  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;
  logic             rs_hit, rt_hit, raw;

  // No forwarding and no write-through: any in-flight match must wait out WB.
  always_comb begin
    rs_hit = (id_rs != '0) &&
             (sb_hit(sb_ex_q, id_rs) || sb_hit(sb_mem_q, id_rs) || sb_hit(sb_wb_q, id_rs));
    rt_hit = id_uses_rt && (id_rt != '0) &&
             (sb_hit(sb_ex_q, id_rt) || sb_hit(sb_mem_q, id_rt) || sb_hit(sb_wb_q, id_rt));
    raw    = id_valid && !pcsrc_mem && (rs_hit || rt_hit);
  end

  always_comb begin
    sb_ex_d  = '0;
    sb_mem_d = '0;
    if (!pcsrc_mem) begin
      sb_mem_d = sb_ex_q;
      if (id_valid && !raw) begin
        sb_ex_d.valid = id_reg_write && (id_rd != '0);
        sb_ex_d.addr  = id_rd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (pcsrc_mem) state_d = FLUSH;
    else if (raw)  state_d = STALL;
    else           state_d = RUN;
  end

  always_comb begin
    run_d = '0;
    if (raw) run_d = (run_q == RUN_W'(MAX_STALL + 1)) ? run_q : run_q + RUN_W'(1);
    err_d = err_q || (raw && (run_q == RUN_W'(MAX_STALL)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_ex_q  <= '0;
      sb_mem_q <= '0;
      sb_wb_q  <= '0;
      state_q  <= RUN;
      run_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      sb_ex_q  <= sb_ex_d;
      sb_mem_q <= sb_mem_d;
      sb_wb_q  <= sb_mem_q;
      state_q  <= state_d;
      run_q    <= run_d;
      err_q    <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (raw),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pcsrc_mem),
    .count (flush_cnt)
  );

  assign stall        = raw;
  assign pc_en        = !raw;
  assign if_id_en     = !raw;
  assign id_ex_bubble = raw || pcsrc_mem;
  assign if_id_flush  = pcsrc_mem;
  assign ex_mem_flush = pcsrc_mem;
  assign state        = state_q;
  assign err_sticky   = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against an in-flight
// destination-list reference model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rt, id_reg_write, pcsrc_mem;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_flush, stall, err_sticky;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // model: destination register of the instruction in EX/MEM/WB, -1 if none
  int m_ex, m_mem, m_wb;
  int m_state, m_stall_cnt, m_flush_cnt, m_run;
  bit m_err;
  bit obs_stall;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .pcsrc_mem    (pcsrc_mem),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_flush (ex_mem_flush),
    .stall        (stall),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .err_sticky   (err_sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_flight(input int r);
    return (r != 0) && (r == m_ex || r == m_mem || r == m_wb);
  endfunction

  task automatic model_reset();
    m_ex = -1; m_mem = -1; m_wb = -1;
    m_state = 0; m_stall_cnt = 0; m_flush_cnt = 0; m_run = 0; m_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    id_rd = 0; id_reg_write = 0; pcsrc_mem = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc_en", pc_en, 1);
    check("rst_if_id_en", if_id_en, 1);
    check("rst_state", state, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_err", err_sticky, 0);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one ID-stage cycle from negedge, compare, then advance the model.
  task automatic step(input bit v, input int rs, input int rt, input bit urt,
                      input int rd, input bit rw, input bit pc);
    bit raw;
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt;
    id_rd = 5'(rd); id_reg_write = rw; pcsrc_mem = pc;
    #1;
    raw = v && !pc && (in_flight(rs) || (urt && in_flight(rt)));
    check("stall", stall, raw);
    check("pc_en", pc_en, !raw);
    check("if_id_en", if_id_en, !raw);
    check("if_id_flush", if_id_flush, pc);
    check("id_ex_bubble", id_ex_bubble, raw || pc);
    check("ex_mem_flush", ex_mem_flush, pc);
    check("state", state, m_state);
    check("stall_cnt", stall_cnt, m_stall_cnt);
    check("flush_cnt", flush_cnt, m_flush_cnt);
    check("err_sticky", err_sticky, m_err);
    obs_stall = stall;
    @(posedge clk);
    m_wb = m_mem;
    if (pc) begin
      m_mem = -1; m_ex = -1;
    end else begin
      m_mem = m_ex;
      m_ex  = (raw || !v) ? -1 : ((rw && rd != 0) ? rd : -1);
    end
    m_state = pc ? 2 : (raw ? 1 : 0);
    if (raw && m_stall_cnt < 65535) m_stall_cnt++;
    if (pc && m_flush_cnt < 65535) m_flush_cnt++;
    if (raw) begin
      m_run++;
      if (m_run >= 4) m_err = 1;
    end else m_run = 0;
    @(negedge clk);
  endtask

  initial begin
    int stalls;
    @(negedge clk);
    do_reset();

    // writer rd=3 then dependent reader rs=3: three-cycle stall
    step(1, 1, 2, 0, 3, 1, 0);
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 3, 0, 0, 9, 1, 0);
      stalls += obs_stall;
    end
    check("raw_ex_stalls", stalls, 3);
    check("raw_ex_stall_cnt", stall_cnt, 3);
    check("raw_ex_state", state, 0);

    // writer rd=5, independent, rt reader: two stalls
    step(1, 1, 1, 0, 5, 1, 0);
    step(1, 2, 2, 1, 6, 0, 0);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 5, 1, 8, 0, 0);
      stalls += obs_stall;
    end
    check("raw_rt_stalls", stalls, 2);

    // same shape, rt not read: no stall
    step(1, 1, 1, 0, 5, 1, 0);
    step(1, 2, 2, 1, 6, 0, 0);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 5, 0, 8, 0, 0);
      stalls += obs_stall;
    end
    check("rt_unused_stalls", stalls, 0);

    // register 0 never hazards
    step(1, 1, 1, 0, 0, 1, 0);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 4, 0, 0);
      stalls += obs_stall;
    end
    check("r0_stalls", stalls, 0);

    // stall on rs=7 interrupted by a taken branch
    do_reset();
    step(1, 1, 1, 0, 7, 1, 0);
    step(1, 7, 7, 1, 2, 1, 0);
    check("pre_flush_stall", obs_stall, 1);
    step(1, 7, 7, 1, 2, 1, 1);
    check("flush_stall", obs_stall, 0);
    check("flush_state", state, 2);
    check("flush_cnt_one", flush_cnt, 1);
    check("flush_sb_ex", dut.sb_ex_q.valid, 0);
    check("flush_sb_mem", dut.sb_mem_q.valid, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // sustained dependency via forced EX entry: err on the 4th stall cycle
    do_reset();
    force dut.sb_ex_q = 6'b1_00111;
    id_valid = 1; id_rs = 5'd7; id_reg_write = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("forced_stall", stall, 1);
      check("err_before_run4", err_sticky, 0);
      @(posedge clk);
      @(negedge clk);
    end
    check("err_after_run4", err_sticky, 1);
    release dut.sb_ex_q;
    id_valid = 0;
    repeat (4) @(negedge clk);
    check("err_sticks", err_sticky, 1);
    do_reset();

    // random traffic against the model, with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
